// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-level round-robin arbiter sharing one UART transmitter between two byte streams
module uart_tx_arbiter #(
  parameter int TIMEOUT = 262143,
  parameter int MAX_LEN = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_byte0,
  input  logic [7:0] req_byte1,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic [7:0] tx_byte,
  output logic       tx_DV,
  input  logic       uart_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err,
  output logic       len_err
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [7:0]      LEN_CAP = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, WAIT, NEXT} state_t;

  state_t          state, state_nxt;
  logic            last_grant, last_grant_nxt;
  logic [7:0]      byte_cnt, byte_cnt_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            last_flag, last_flag_nxt;
  logic [1:0]      req_ready_nxt, grant_nxt;
  logic [7:0]      tx_byte_nxt;
  logic            tx_DV_nxt, busy_nxt;
  logic            frame_done_nxt, timeout_err_nxt, len_err_nxt;

  logic owner;
  logic pick;
  logic load, load_sel;
  logic release_frame;

  // While busy, grant is one-hot so bit 1 alone identifies the owner.
  assign owner = grant[1];

  always_comb begin
    pick = 1'b0;
    case (req_valid)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    byte_cnt_nxt    = byte_cnt;
    wd_nxt          = wd;
    last_flag_nxt   = last_flag;
    req_ready_nxt   = 2'b00;
    grant_nxt       = grant;
    tx_byte_nxt     = tx_byte;
    tx_DV_nxt       = 1'b0;
    frame_done_nxt  = 1'b0;
    timeout_err_nxt = 1'b0;
    len_err_nxt     = 1'b0;
    load            = 1'b0;
    load_sel        = 1'b0;
    release_frame   = 1'b0;

    case (state)
      IDLE: begin
        if (|req_valid) begin
          load         = 1'b1;
          load_sel     = pick;
          byte_cnt_nxt = 8'd1;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        // tx_DV is still high in the first WAIT cycle; a done pulse there belongs to an older byte.
        if (uart_done && !tx_DV) begin
          if (last_flag) begin
            frame_done_nxt = 1'b1;
            release_frame  = 1'b1;
          end else if (byte_cnt == LEN_CAP) begin
            len_err_nxt   = 1'b1;
            release_frame = 1'b1;
          end else begin
            wd_nxt    = '0;
            state_nxt = NEXT;
          end
        end else if (wd == WD_LAST) begin
          timeout_err_nxt = 1'b1;
          release_frame   = 1'b1;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      NEXT: begin
        if (req_valid[owner]) begin
          load         = 1'b1;
          load_sel     = owner;
          byte_cnt_nxt = byte_cnt + 8'd1;
          state_nxt    = WAIT;
        end else if (wd == WD_LAST) begin
          timeout_err_nxt = 1'b1;
          release_frame   = 1'b1;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      grant_nxt     = load_sel ? 2'b10 : 2'b01;
      req_ready_nxt = load_sel ? 2'b10 : 2'b01;
      tx_byte_nxt   = load_sel ? req_byte1 : req_byte0;
      tx_DV_nxt     = 1'b1;
      last_flag_nxt = req_last[load_sel];
      wd_nxt        = '0;
    end

    if (release_frame) begin
      last_grant_nxt = owner;
      grant_nxt      = 2'b00;
      state_nxt      = IDLE;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      byte_cnt    <= 8'd0;
      wd          <= '0;
      last_flag   <= 1'b0;
      req_ready   <= 2'b00;
      grant       <= 2'b00;
      tx_byte     <= 8'h00;
      tx_DV       <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      byte_cnt    <= byte_cnt_nxt;
      wd          <= wd_nxt;
      last_flag   <= last_flag_nxt;
      req_ready   <= req_ready_nxt;
      grant       <= grant_nxt;
      tx_byte     <= tx_byte_nxt;
      tx_DV       <= tx_DV_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      timeout_err <= timeout_err_nxt;
      len_err     <= len_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench for uart_tx_arbiter against a frame-level reference model
module tb_uart_tx_arbiter;

  localparam int TIMEOUT = 50;
  localparam int MAX_LEN = 4;
  localparam int K_TX = 0, K_DONE = 1, K_TO = 2, K_LEN = 3;

  typedef struct {
    int kind;
    int who;
    int data;
    int a_evt;
    int a_tx;
    int a_done;
  } tok_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_byte0, req_byte1;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic [7:0] tx_byte;
  logic       tx_DV;
  logic       uart_done;
  logic [1:0] grant;
  logic       busy;
  logic       frame_done, timeout_err, len_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT(TIMEOUT), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_byte0(req_byte0),
    .req_byte1(req_byte1), .req_last(req_last), .req_ready(req_ready),
    .tx_byte(tx_byte), .tx_DV(tx_DV), .uart_done(uart_done), .grant(grant),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .len_err(len_err)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0, last_evt = 0, last_tx = 0, last_done = 0;
  tok_t obs[$];
  tok_t expq[$];

  bit         active[2], started[2], lastok[2];
  int         flen[2], pos[2], stall[2];
  logic [7:0] fb[2][MAX_LEN+1];
  int         fault[32];
  int         txn = 0, cnt = 0;
  bit         stray = 1'b0;
  int         m_lg = 1;

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  // One negedge: observe outputs, then advance requester and UART models.
  task automatic step();
    tok_t tk;
    bit   offer;
    @(negedge clk);
    cyc++;
    chk("busy_vs_grant", int'(busy), int'(|grant));
    chk("grant_onehot", int'($countones(grant) <= 1), 1);
    if (tx_DV) begin
      chk("ready_matches_grant", int'(req_ready), int'(grant));
      tk = '{K_TX, int'(grant[1]), int'(tx_byte), cyc - last_evt, -1, -1};
      obs.push_back(tk);
      last_tx = cyc;
    end else begin
      chk("ready_without_dv", int'(req_ready), 0);
    end
    if (frame_done) begin tk = '{K_DONE, -1, -1, -1, -1, -1}; obs.push_back(tk); end
    if (len_err)    begin tk = '{K_LEN, -1, -1, -1, -1, -1}; obs.push_back(tk); end
    if (timeout_err) begin
      tk = '{K_TO, -1, -1, -1, cyc - last_tx, cyc - last_done};
      obs.push_back(tk);
    end
    if (frame_done || len_err || timeout_err) last_evt = cyc;

    for (int i = 0; i < 2; i++) begin
      if (reset) active[i] = 1'b0;
      else if (active[i]) begin
        if (req_ready[i]) begin
          started[i] = 1'b1;
          pos[i]++;
          if (lastok[i] && pos[i] == flen[i]) active[i] = 1'b0;
        end
        if (started[i] && (frame_done || timeout_err || len_err)) active[i] = 1'b0;
      end
      offer = active[i] && pos[i] < flen[i] && (stall[i] == 0 || pos[i] + 1 < stall[i]);
      req_valid[i] = offer;
      req_last[i]  = offer && lastok[i] && (pos[i] == flen[i] - 1);
      if (i == 0) req_byte0 = offer ? fb[0][pos[0]] : 8'h00;
      else        req_byte1 = offer ? fb[1][pos[1]] : 8'h00;
    end

    uart_done = 1'b0;
    if (reset) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin uart_done = 1'b1; last_done = cyc; end
      end
      if (stray) begin uart_done = 1'b1; stray = 1'b0; end
      if (tx_DV) begin
        txn++;
        if (fault[txn] == 0) cnt = $urandom_range(1, 20);
        else if (fault[txn] == 2) uart_done = 1'b1;
      end
    end
  endtask

  task automatic run_round(input bit force_both);
    int   pend, n, gidx, mode, k, neff, nsent, who, t;
    int   order[2];
    tok_t tk;
    obs.delete();
    expq.delete();
    for (int f = 0; f < 32; f++) fault[f] = 0;
    txn = 0;
    pend = force_both ? 3 : $urandom_range(1, 3);
    order[0] = (pend == 3) ? 1 - m_lg : (pend == 2 ? 1 : 0);
    order[1] = 1 - order[0];
    n = (pend == 3) ? 2 : 1;
    gidx = 0;
    for (int f = 0; f < n; f++) begin
      who = order[f];
      flen[who]   = $urandom_range(1, MAX_LEN + 1);
      lastok[who] = (flen[who] <= MAX_LEN);
      for (int j = 0; j < flen[who]; j++) fb[who][j] = 8'($urandom);
      neff = lastok[who] ? flen[who] : MAX_LEN;
      mode = force_both ? 0 : $urandom_range(0, 5);
      if (mode == 5 && neff < 2) mode = 0;
      stall[who] = 0;
      k = 0;
      if (mode == 3 || mode == 4) k = $urandom_range(1, neff);
      if (mode == 5) begin k = $urandom_range(2, neff); stall[who] = k; end
      nsent = (mode == 3 || mode == 4) ? k : (mode == 5 ? k - 1 : neff);
      if (mode == 3) fault[gidx + k] = 1;
      if (mode == 4) fault[gidx + k] = 2;
      for (int j = 0; j < nsent; j++) begin
        tk = '{K_TX, who, int'(fb[who][j]), (j == 0) ? 1 : -1, -1, -1};
        expq.push_back(tk);
      end
      if (mode == 3 || mode == 4) tk = '{K_TO, -1, -1, -1, TIMEOUT, -1};
      else if (mode == 5)         tk = '{K_TO, -1, -1, -1, -1, TIMEOUT + 1};
      else if (lastok[who])       tk = '{K_DONE, -1, -1, -1, -1, -1};
      else                        tk = '{K_LEN, -1, -1, -1, -1, -1};
      expq.push_back(tk);
      gidx += nsent;
      m_lg = who;
      active[who]  = 1'b1;
      started[who] = 1'b0;
      pos[who]     = 0;
    end
    last_evt = cyc + 1;
    t = 0;
    step();
    while ((active[0] || active[1] || busy || cnt != 0) && t < 3000) begin
      step();
      t++;
    end
    chk("round_quiesce", int'(t < 3000), 1);
    repeat (3) step();
    chk("token_count", obs.size(), expq.size());
    for (int q = 0; q < expq.size() && q < obs.size(); q++) begin
      chk("kind", obs[q].kind, expq[q].kind);
      if (expq[q].who    != -1) chk("tx_owner", obs[q].who, expq[q].who);
      if (expq[q].data   != -1) chk("tx_byte", obs[q].data, expq[q].data);
      if (expq[q].a_evt  != -1) chk("grant_latency", obs[q].a_evt, expq[q].a_evt);
      if (expq[q].a_tx   != -1) chk("timeout_after_dv", obs[q].a_tx, expq[q].a_tx);
      if (expq[q].a_done != -1) chk("timeout_after_done", obs[q].a_done, expq[q].a_done);
    end
  endtask

  initial begin
    int t;
    reset = 1'b1;
    req_valid = 2'b00;
    req_byte0 = 8'h00;
    req_byte1 = 8'h00;
    req_last = 2'b00;
    uart_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; started[i] = 1'b0; lastok[i] = 1'b0;
      flen[i] = 0; pos[i] = 0; stall[i] = 0;
    end
    for (int f = 0; f < 32; f++) fault[f] = 0;

    repeat (3) step();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    chk("rst_tx_dv", int'(tx_DV), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_len_err", int'(len_err), 0);
    reset = 1'b0;
    step();

    for (int r = 0; r < 60; r++) run_round(r < 2);

    // Reset while byte 2 of a frame is in flight; a late uart_done must not disturb IDLE.
    obs.delete();
    for (int f = 0; f < 32; f++) fault[f] = 0;
    txn = 0;
    fault[2] = 1;
    flen[0] = 3; lastok[0] = 1'b1; stall[0] = 0;
    fb[0][0] = 8'hA5; fb[0][1] = 8'h01; fb[0][2] = 8'h02;
    active[0] = 1'b1; started[0] = 1'b0; pos[0] = 0;
    t = 0;
    while (obs.size() < 2 && t < 500) begin step(); t++; end
    chk("rst_test_reached_byte2", obs.size(), 2);
    repeat (3) step();
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    chk("midrst_tx_dv", int'(tx_DV), 0);
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    chk("midrst_tx_byte", int'(tx_byte), 0);
    step();
    reset = 1'b0;
    stray = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stray_grant", int'(grant), 0);
      chk("stray_busy", int'(busy), 0);
      chk("stray_tx_dv", int'(tx_DV), 0);
      chk("stray_pulses", int'({frame_done, timeout_err, len_err}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
